// File: rtl/network_rbfu_in_pkg.sv
// Shared configuration for the RBFU read-side crossbar: lane count, word and select widths.
// Lane i of any packed bus lives at [i*W +: W].
package network_rbfu_in_pkg;

  localparam int unsigned PairsCfg     = 2;
  localparam int unsigned DataWidthCfg = 12;
  localparam int unsigned MapCfg       = 2;
  localparam int unsigned NLanesCfg    = 2 * PairsCfg;
  localparam int unsigned RdLatCfg     = 1;

endpackage

// File: rtl/rbfu_sel_delay.sv
// Delay line carrying {valid, select bus} to line up with bank read latency.
// flush_i clears only the valid bits; select data keeps shifting.
module rbfu_sel_delay #(
  parameter int unsigned Depth = 1,
  parameter int unsigned W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         vld_i,
  input  logic [W-1:0] sel_i,
  output logic         vld_o,
  output logic [W-1:0] sel_o
);

  logic [Depth-1:0]        vld_q;
  logic [Depth-1:0][W-1:0] sel_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      sel_q <= '0;
    end else begin
      vld_q[0] <= vld_i & ~flush_i;
      sel_q[0] <= sel_i;
      for (int unsigned k = 1; k < Depth; k++) begin
        vld_q[k] <= vld_q[k-1] & ~flush_i;
        sel_q[k] <= sel_q[k-1];
      end
    end
  end

  assign vld_o = vld_q[Depth-1];
  assign sel_o = sel_q[Depth-1];

endmodule

// File: rtl/network_rbfu_in.sv
// Bank-to-RBFU read crossbar: out lane i takes bank word sel[i], registered with a valid flag.
// Define RBFU_IN_PERM_CHECK_EN to build the sticky select-conflict detector (perm_err_o).
module network_rbfu_in
  import network_rbfu_in_pkg::*;
#(
  parameter int unsigned NLanes    = NLanesCfg,
  parameter int unsigned DataWidth = DataWidthCfg,
  parameter int unsigned SelW      = MapCfg,
  parameter int unsigned RdLat     = RdLatCfg
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        issue_valid_i,
  input  logic [NLanes*SelW-1:0]      sel_ai_bus_i,
  input  logic [NLanes*DataWidth-1:0] d_out_bus_i,
  output logic [NLanes*DataWidth-1:0] bf_in_bus_o,
  output logic                        bf_in_valid_o,
  output logic                        perm_err_o
);

  localparam int unsigned SelBusW  = NLanes * SelW;
  localparam int unsigned DataBusW = NLanes * DataWidth;

  logic [SelBusW-1:0]  sel_d;
  logic                vld_d;
  logic [DataBusW-1:0] routed;
  logic [DataBusW-1:0] bf_in_bus_q;
  logic                bf_in_valid_q;

  rbfu_sel_delay #(
    .Depth (RdLat),
    .W     (SelBusW)
  ) u_sel_delay (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .vld_i   (issue_valid_i),
    .sel_i   (sel_ai_bus_i),
    .vld_o   (vld_d),
    .sel_o   (sel_d)
  );

  // Out-of-range selects route a zero word rather than wrapping.
  always_comb begin
    routed = '0;
    for (int unsigned i = 0; i < NLanes; i++) begin
      if (32'(sel_d[i*SelW +: SelW]) < NLanes) begin
        routed[i*DataWidth +: DataWidth] =
          d_out_bus_i[32'(sel_d[i*SelW +: SelW])*DataWidth +: DataWidth];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bf_in_bus_q   <= '0;
      bf_in_valid_q <= 1'b0;
    end else begin
      bf_in_bus_q   <= routed;
      bf_in_valid_q <= vld_d & ~flush_i;
    end
  end

  assign bf_in_bus_o   = bf_in_bus_q;
  assign bf_in_valid_o = bf_in_valid_q;

`ifdef RBFU_IN_PERM_CHECK_EN
  logic conflict;
  logic perm_err_d, perm_err_q;

  always_comb begin
    conflict = 1'b0;
    for (int unsigned i = 0; i < NLanes; i++) begin
      if (32'(sel_d[i*SelW +: SelW]) >= NLanes) begin
        conflict = 1'b1;
      end
      for (int unsigned j = i + 1; j < NLanes; j++) begin
        if (sel_d[i*SelW +: SelW] == sel_d[j*SelW +: SelW]) begin
          conflict = 1'b1;
        end
      end
    end
  end

  always_comb begin
    perm_err_d = perm_err_q | (vld_d & conflict);
    if (flush_i) begin
      perm_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perm_err_q <= 1'b0;
    end else begin
      perm_err_q <= perm_err_d;
    end
  end

  assign perm_err_o = perm_err_q;
`else
  assign perm_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_network_rbfu_in.sv
// Randomised bench for network_rbfu_in against a cycle-history reference model.
// Honours RBFU_IN_PERM_CHECK_EN to decide whether perm_err is expected to fire.
module tb_network_rbfu_in;

  localparam int unsigned NLanes   = 4;
  localparam int unsigned SelW     = 2;
  localparam int unsigned DW       = 12;
  localparam int unsigned RdLat    = 1;
  localparam int unsigned SelBusW  = NLanes * SelW;
  localparam int unsigned DataBusW = NLanes * DW;
  localparam int unsigned MaxCyc   = 2048;
`ifdef RBFU_IN_PERM_CHECK_EN
  localparam bit PermEn = 1'b1;
`else
  localparam bit PermEn = 1'b0;
`endif

  logic                clk;
  logic                rst_ni;
  logic                flush;
  logic                issue_valid;
  logic [SelBusW-1:0]  sel_bus;
  logic [DataBusW-1:0] d_out_bus;
  logic [DataBusW-1:0] bf_in_bus;
  logic                bf_in_valid;
  logic                perm_err;

  network_rbfu_in #(
    .NLanes    (NLanes),
    .DataWidth (DW),
    .SelW      (SelW),
    .RdLat     (RdLat)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .flush_i       (flush),
    .issue_valid_i (issue_valid),
    .sel_ai_bus_i  (sel_bus),
    .d_out_bus_i   (d_out_bus),
    .bf_in_bus_o   (bf_in_bus),
    .bf_in_valid_o (bf_in_valid),
    .perm_err_o    (perm_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned         n_vec;
  int unsigned         n_err;
  int unsigned         cyc;
  int unsigned         seg;
  logic                perm_m;
  logic                iv_h  [MaxCyc];
  logic                fl_h  [MaxCyc];
  logic [SelBusW-1:0]  sel_h [MaxCyc];
  logic [DataBusW-1:0] d_h   [MaxCyc];

  localparam logic [DataBusW-1:0] DataAbcd = {12'h0D3, 12'h0C2, 12'h0B1, 12'h0A0};
  localparam logic [SelBusW-1:0]  SelIdent = {2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [SelBusW-1:0]  SelRev   = {2'd0, 2'd1, 2'd2, 2'd3};
  localparam logic [SelBusW-1:0]  SelDup   = {2'd1, 2'd1, 2'd2, 2'd0};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output lane i is the bank word whose index sits in select field i; unknown banks give zero.
  function automatic logic [DataBusW-1:0] route(input logic [SelBusW-1:0] s,
                                                input logic [DataBusW-1:0] d);
    logic [DataBusW-1:0] r;
    int unsigned         src;
    r = '0;
    for (int i = 0; i < NLanes; i++) begin
      src = (s >> (i * SelW)) % (1 << SelW);
      if (src < NLanes) r = r | (((d >> (src * DW)) % (1 << DW)) << (i * DW));
    end
    return r;
  endfunction

  function automatic bit not_perm(input logic [SelBusW-1:0] s);
    int unsigned hits [NLanes];
    int unsigned src;
    for (int i = 0; i < NLanes; i++) hits[i] = 0;
    for (int i = 0; i < NLanes; i++) begin
      src = (s >> (i * SelW)) % (1 << SelW);
      if (src >= NLanes) return 1'b1;
      hits[src]++;
    end
    for (int i = 0; i < NLanes; i++) if (hits[i] != 1) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive inputs, check model at negedge, advance model over the edge.
  task automatic cycle(input logic iv, input logic [SelBusW-1:0] sel,
                       input logic [DataBusW-1:0] d, input logic fl);
    logic                exp_v;
    logic [DataBusW-1:0] exp_bf;
    logic                v_stage;
    int unsigned         t;
    iv_h[cyc] = iv;
    fl_h[cyc] = fl;
    sel_h[cyc] = sel;
    d_h[cyc] = d;
    issue_valid = iv;
    sel_bus = sel;
    d_out_bus = d;
    flush = fl;
    @(negedge clk);
    exp_v = 1'b0;
    exp_bf = '0;
    if (cyc >= seg + RdLat + 1) begin
      t = cyc - RdLat - 1;
      exp_v = iv_h[t];
      for (int unsigned c = t; c < cyc; c++) if (fl_h[c]) exp_v = 1'b0;
      exp_bf = route(sel_h[t], d_h[cyc-1]);
    end else if (cyc >= seg + 1) begin
      exp_bf = route('0, d_h[cyc-1]);
    end
    check_eq("bf_in_valid", 64'(bf_in_valid), 64'(exp_v));
    check_eq("bf_in_bus", 64'(bf_in_bus), 64'(exp_bf));
    check_eq("perm_err", 64'(perm_err), 64'(perm_m));
    if (cyc >= seg + RdLat) begin
      t = cyc - RdLat;
      v_stage = iv_h[t];
      for (int unsigned c = t; c < cyc; c++) if (fl_h[c]) v_stage = 1'b0;
      if (PermEn && v_stage && not_perm(sel_h[t])) perm_m = 1'b1;
    end
    if (fl) perm_m = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input bit check_now);
    rst_ni = 1'b0;
    #1;
    if (check_now) begin
      check_eq("rst_bf_in_bus", 64'(bf_in_bus), 64'd0);
      check_eq("rst_bf_in_valid", 64'(bf_in_valid), 64'd0);
      check_eq("rst_perm_err", 64'(perm_err), 64'd0);
    end
    issue_valid = 1'b0;
    flush = 1'b0;
    sel_bus = '0;
    d_out_bus = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    seg = cyc;
    perm_m = 1'b0;
  endtask

  function automatic logic [DataBusW-1:0] rnd_data();
    return DataBusW'({$urandom, $urandom});
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    seg = 0;
    perm_m = 1'b0;
    rst_ni = 1'b1;
    issue_valid = 1'b0;
    flush = 1'b0;
    sel_bus = '0;
    d_out_bus = '0;
    #2;
    do_reset(1'b1);

    // Identity then reverse, each followed by idle cycles so valid is a single pulse.
    cycle(1'b1, SelIdent, rnd_data(), 1'b0);
    cycle(1'b0, SelRev, DataAbcd, 1'b0);
    check_eq("ident_bus", 64'(bf_in_bus), 64'({12'h0D3, 12'h0C2, 12'h0B1, 12'h0A0}));
    check_eq("ident_valid", 64'(bf_in_valid), 64'd1);
    cycle(1'b1, SelRev, rnd_data(), 1'b0);
    cycle(1'b0, SelIdent, DataAbcd, 1'b0);
    check_eq("rev_bus", 64'(bf_in_bus), 64'({12'h0A0, 12'h0B1, 12'h0C2, 12'h0D3}));
    cycle(1'b0, SelIdent, rnd_data(), 1'b0);
    cycle(1'b0, SelIdent, rnd_data(), 1'b0);

    // Streaming: four back-to-back issues, alternating selects.
    for (int k = 0; k < 4; k++) cycle(1'b1, (k % 2 == 0) ? SelIdent : SelRev, rnd_data(), 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, SelIdent, rnd_data(), 1'b0);

    // Flush kills the in-flight issue; the next issue is unaffected.
    cycle(1'b1, SelIdent, rnd_data(), 1'b0);
    cycle(1'b0, SelIdent, rnd_data(), 1'b1);
    cycle(1'b1, SelRev, rnd_data(), 1'b0);
    cycle(1'b0, SelIdent, rnd_data(), 1'b0);
    cycle(1'b0, SelIdent, rnd_data(), 1'b0);
    cycle(1'b1, SelRev, rnd_data(), 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, SelIdent, rnd_data(), 1'b0);

    // Duplicate select: perm_err (when built) sets, survives legal traffic, cleared by flush.
    cycle(1'b1, SelDup, rnd_data(), 1'b0);
    cycle(1'b0, SelIdent, DataAbcd, 1'b0);
    check_eq("dup_bus", 64'(bf_in_bus), 64'({12'h0B1, 12'h0B1, 12'h0C2, 12'h0A0}));
    check_eq("dup_perm_err", 64'(perm_err), 64'(PermEn));
    for (int k = 0; k < 3; k++) cycle(1'b1, SelIdent, rnd_data(), 1'b0);
    cycle(1'b0, SelIdent, rnd_data(), 1'b1);
    cycle(1'b0, SelIdent, rnd_data(), 1'b0);

    // Random traffic with occasional flushes.
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom % 4) != 0,
            ($urandom % 3 == 0) ? SelBusW'($urandom) : (($urandom % 2) ? SelIdent : SelRev),
            rnd_data(), ($urandom % 12) == 0);
    end

    // Async reset mid-stream, between edges, then resume.
    for (int k = 0; k < 3; k++) cycle(1'b1, SelRev, rnd_data(), 1'b0);
    #2;
    do_reset(1'b1);
    for (int k = 0; k < 40; k++) begin
      cycle(($urandom % 2) != 0, SelBusW'($urandom), rnd_data(), ($urandom % 10) == 0);
    end
    cycle(1'b0, SelIdent, rnd_data(), 1'b0);
    cycle(1'b0, SelIdent, rnd_data(), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/network_rbfu_in.md
Name: network_RBFU_in

Overview:
- Read-side crossbar between memory banks and the radix-butterfly units (RBFU); the inverse direction of the RBFU-to-bank write network.
- Accepts per-lane bank-select indices at read-issue time and delays them to match bank read latency.
- Routes each bank's read word to its RBFU input lane (out lane i = bank word sel[i]) and registers the result with a valid flag.

Parameters:
- N_LANES, 2*`P, number of bank/RBFU lanes.
- DATA_WIDTH, `DATA_WIDTH, bits per lane word.
- SELW, `MAP, bits per lane select index.
- RD_LAT, 1, bank read latency in cycles (≥1) between select issue and read-data arrival.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of the valid pipeline.
- issue_valid  input  1  select bus valid; aligned with bank read issue.
- sel_AI_bus  input  N_LANES*SELW  packed per-lane source-bank index; lane i at [i*SELW +: SELW].
- d_out_bus  input  N_LANES*DATA_WIDTH  packed bank read data; valid RD_LAT cycles after issue.
- bf_in_bus  output  N_LANES*DATA_WIDTH  packed RBFU input words, registered.
- bf_in_valid  output  1  bf_in_bus holds a routed vector.
- perm_err  output  1  sticky select-conflict flag (see Optional Feature).

Behaviour:
- Reset (rst=0, async): all delay-line stages, bf_in_bus, bf_in_valid and perm_err are cleared to 0.
- Select delay:
  - sel_AI_bus and issue_valid enter an RD_LAT-deep register chain; no backpressure, advances every cycle.
  - The stage-RD_LAT output (sel_d, vld_d) is aligned with d_out_bus.
- Routing (combinational at stage RD_LAT):
  - word_i = d_out lane sel_d[i] when sel_d[i] < N_LANES.
  - sel_d[i] ≥ N_LANES gives word_i = 0.
- Output register:
  - Every cycle bf_in_bus <= routed words and bf_in_valid <= vld_d & ~flush.
  - Total latency from issue to bf_in_valid is RD_LAT+1 cycles.
  - Back-to-back issues give back-to-back outputs at full rate.
- Data gating: bf_in_bus updates every cycle regardless of valid. Consumers qualify with bf_in_valid.
- flush=1:
  - Clears every valid bit in the delay chain and the bf_in_valid register on the next edge.
  - Select data is not cleared.
  - An issue_valid coincident with flush is dropped.
- Reset mid-stream discards all in-flight vectors; the first valid output after release is RD_LAT+1 cycles after the next issue.
- Selects are not required to be a permutation. Broadcast (duplicate sel) is legal unless the checker is enabled.

Optional Feature:
- Macro: RBFU_IN_PERM_CHECK_EN.
- When defined:
  - At stage RD_LAT, if vld_d=1 and any two lanes hold equal sel_d, or any sel_d ≥ N_LANES, perm_err is set on the next edge.
  - perm_err is sticky; it is cleared only by rst or flush.
  - flush takes priority over a simultaneous set.
- When undefined: perm_err is tied to 0 and no comparator logic is generated.

Decomposition:
- Shared package/parameter.v owns `P, `DATA_WIDTH, `MAP and the derived N_LANES, plus the pack/unpack slice convention (lane i at i*W).
- One sub-module: rbfu_sel_delay.
  - Parameterised by DEPTH and W.
  - Async active-low reset; carries {valid, sel bus}.
  - Has a flush input that clears the valid bit only.
- Routing mux and output register stay in the top level.

Test Plan (N_LANES=4, SELW=2, DATA_WIDTH=12, RD_LAT=1):
- Identity: issue sel={3,2,1,0} (lane3..lane0); next cycle d_out={0x0D3,0x0C2,0x0B1,0x0A0} -> two cycles after issue bf_in={0x0D3,0x0C2,0x0B1,0x0A0}, bf_in_valid=1 for exactly one cycle.
- Reverse: sel={0,1,2,3} with the same data -> bf_in={0x0A0,0x0B1,0x0C2,0x0D3}.
- Streaming: issue on 4 consecutive cycles with alternating identity/reverse selects -> 4 consecutive valid outputs in order, each routed by its own select.
- Flush: issue at cycle t, flush at t+1 -> bf_in_valid stays 0 at t+2. An issue at t+2 yields valid at t+4.
- Async reset: assert rst=0 mid-stream between clock edges -> bf_in_bus=0, bf_in_valid=0 and perm_err=0 immediately, without waiting for an edge.
- RBFU_IN_PERM_CHECK_EN: sel={1,1,2,0} valid -> perm_err=1 two cycles after issue, holds through later legal vectors, and clears after flush. With the macro undefined, perm_err stays 0.
